digital_tube: RTL
=================

DIGITAL_TUBE -- requirements
Module: digital_tube

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each digit stays selected; legal range 2..2^20.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Addr  input  1  word select: 0 = data register DATA, 1 = control register CTRL.
REQ-005 WE  input  1  bus write strobe, sampled on the rising clk edge.
REQ-006 BE  input  4  byte enables for writes; BE[i] covers DIn[8i+7:8i].
REQ-007 DIn  input  32  bus write data.
REQ-008 DOut  output  32  combinational readback of the selected register.
REQ-009 Sel0  output  4  active-low digit select for tube group 0, which shows DATA[15:0].
REQ-010 Seg0  output  8  active-low segments {dp,g,f,e,d,c,b,a} for group 0.
REQ-011 Sel1  output  4  active-low digit select for tube group 1, which shows DATA[31:16].
REQ-012 Seg1  output  8  active-low segments for group 1.

Function
REQ-013 A write SHALL occur when WE=1 at a rising edge; only bytes with BE[i]=1 SHALL update.
REQ-014 The new register value SHALL be visible on DOut in the cycle after the write edge.
REQ-015 CTRL SHALL implement bit 0 (EN) only; CTRL bits 31:1 SHALL ignore writes and read as 0.
REQ-016 DOut SHALL equal DATA when Addr=0 and {31'b0, EN} when Addr=1.
REQ-017 A divider counter SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-018 A 2-bit digit index SHALL increment, modulo 4 (3 -> 0), on each cycle the divider reaches SCAN_DIV-1.
REQ-019 For digit index k, Sel0 and Sel1 SHALL each drive bit k low and the other bits high.
REQ-020 Seg0 SHALL show the hex glyph of DATA[4k+3:4k], and Seg1 the glyph of DATA[16+4k+3:16+4k].
REQ-021 Glyphs SHALL be the standard 0-9, A, b, C, d, E, F patterns, active-low, with dp always off (bit 7 = 1).
REQ-022 Sel and Seg outputs SHALL be registered and SHALL update on the same edge as the digit index changes.
REQ-023 When EN=0, Sel0 and Sel1 SHALL be 4'b1111 and Seg0 and Seg1 SHALL be 8'hFF; the divider and index SHALL keep running.
REQ-024 A DATA write in the same cycle as an index change: the new nibble SHALL be shown no later than the following cycle.
REQ-025 A write with BE=4'b0000 SHALL change no state.

Reset
REQ-026 While reset=0, all of the following SHALL hold asynchronously: DATA=0, EN=0, divider=0, digit index=0, Sel0=Sel1=4'b1111, Seg0=Seg1=8'hFF.
REQ-027 Reset asserted mid-scan or mid-write SHALL abort any pending write.
REQ-028 After reset deasserts, the first index advance SHALL occur SCAN_DIV cycles after the first active clk edge.

Structure
REQ-029 The shared package SHALL hold the 16 segment-glyph constants, the blank constants (8'hFF and 4'hF), and the register address constants.
REQ-030 One combinational sub-module, hex_to_seg (4-bit nibble in, 8-bit active-low segments out), SHALL be instantiated twice, once per group.
REQ-031 The divider, digit index, and registers SHALL reside in digital_tube itself.

Verification (SCAN_DIV=4)
REQ-032 Reset; write Addr=1 DIn=1 BE=F; write Addr=0 DIn=32'h1234ABCD BE=F -> Sel0 cycles E,D,B,7 (4 cycles each); Seg0 shows D, C, b, A; Seg1 shows 4, 3, 2, 1.
REQ-033 DATA=32'h1234ABCD; write DIn=32'hFFFFFFFF BE=4'b0100 -> DOut=32'h12FFABCD.
REQ-034 EN=1; write Addr=1 DIn=0 -> next cycle Sel0=Sel1=F and Seg0=Seg1=FF; DOut(Addr=1)=0; the index keeps advancing, checked by re-enabling.
REQ-035 Write Addr=1 DIn=32'hFFFFFFFF -> DOut(Addr=1)=32'h00000001.
REQ-036 Assert reset at index 2 mid-dwell -> outputs blank immediately, DATA=0; after release, index 0 holds for 4 cycles.
REQ-037 Write DATA with nibble 0 = 8 on the exact index-advance edge -> Seg0 shows 8'h80 (glyph 8, dp off) no later than the next cycle.

Source files
------------

// File: rtl/digital_tube_pkg.sv
// Shared constants for the two-group hex tube driver: active-low glyphs,
// blanking patterns and the register map.
package digital_tube_pkg;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp held off
    localparam logic [7:0] SEG_HEX_0 = 8'hC0;
    localparam logic [7:0] SEG_HEX_1 = 8'hF9;
    localparam logic [7:0] SEG_HEX_2 = 8'hA4;
    localparam logic [7:0] SEG_HEX_3 = 8'hB0;
    localparam logic [7:0] SEG_HEX_4 = 8'h99;
    localparam logic [7:0] SEG_HEX_5 = 8'h92;
    localparam logic [7:0] SEG_HEX_6 = 8'h82;
    localparam logic [7:0] SEG_HEX_7 = 8'hF8;
    localparam logic [7:0] SEG_HEX_8 = 8'h80;
    localparam logic [7:0] SEG_HEX_9 = 8'h90;
    localparam logic [7:0] SEG_HEX_A = 8'h88;
    localparam logic [7:0] SEG_HEX_B = 8'h83;
    localparam logic [7:0] SEG_HEX_C = 8'hC6;
    localparam logic [7:0] SEG_HEX_D = 8'hA1;
    localparam logic [7:0] SEG_HEX_E = 8'h86;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] SEL_BLANK = 4'hF;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

endpackage

// File: rtl/digital_tube_hex_to_seg.sv
// Combinational nibble-to-glyph decoder for one tube group.
module hex_to_seg
    import digital_tube_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digital_tube.sv
// Bus-writable 8-digit hex display driver: DATA/CTRL registers, a scan
// divider and a 2-bit digit index multiplexing two 4-digit tube groups.
module digital_tube
    import digital_tube_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic [3:0]  Sel0,
    output logic [7:0]  Seg0,
    output logic [3:0]  Sel1,
    output logic [7:0]  Seg1
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_reg, data_next;
    logic             en_reg, en_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       idx_reg, idx_next;
    logic [3:0]       sel_reg, sel_next;
    logic [7:0]       seg0_reg, seg0_next;
    logic [7:0]       seg1_reg, seg1_next;
    logic [3:0]       nibble0, nibble1;
    logic [7:0]       glyph0, glyph1;
    logic             data_wr, ctrl_wr;

    assign data_wr = WE && (Addr == ADDR_DATA);
    assign ctrl_wr = WE && (Addr == ADDR_CTRL);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign data_next[8*gi +: 8] = (data_wr && BE[gi]) ? DIn[8*gi +: 8]
                                                              : data_reg[8*gi +: 8];
        end
    endgenerate

    assign en_next = (ctrl_wr && BE[0]) ? DIn[0] : en_reg;

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (cnt_reg == CNT_MAX) begin
            cnt_next = '0;
            idx_next = idx_reg + 2'd1;
        end
    end

    // Glyphs come from the post-write value so a write landing on an index
    // step is already reflected in the registered outputs of that edge.
    assign nibble0 = data_next[{idx_next, 2'b00} +: 4];
    assign nibble1 = data_next[{1'b1, idx_next, 2'b00} +: 4];

    hex_to_seg u_hex0 (.nibble(nibble0), .seg(glyph0));
    hex_to_seg u_hex1 (.nibble(nibble1), .seg(glyph1));

    always_comb begin
        sel_next  = SEL_BLANK;
        seg0_next = SEG_BLANK;
        seg1_next = SEG_BLANK;
        if (en_next) begin
            sel_next[idx_next] = 1'b0;
            seg0_next          = glyph0;
            seg1_next          = glyph1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg <= '0;
            en_reg   <= 1'b0;
            cnt_reg  <= '0;
            idx_reg  <= '0;
            sel_reg  <= SEL_BLANK;
            seg0_reg <= SEG_BLANK;
            seg1_reg <= SEG_BLANK;
        end else begin
            data_reg <= data_next;
            en_reg   <= en_next;
            cnt_reg  <= cnt_next;
            idx_reg  <= idx_next;
            sel_reg  <= sel_next;
            seg0_reg <= seg0_next;
            seg1_reg <= seg1_next;
        end
    end

    assign DOut = (Addr == ADDR_CTRL) ? {31'b0, en_reg} : data_reg;
    assign Sel0 = sel_reg;
    assign Sel1 = sel_reg;
    assign Seg0 = seg0_reg;
    assign Seg1 = seg1_reg;

endmodule
